// File: rtl/gaussian_pkg.sv
// Shared definitions for the gaussian window sequencer.
//   state_t  : sequencer FSM states (IDLE, CLR, FEED, WAIT)
//   PIX_W    : default pixel/result width
//   WIN_PIX  : default pixels per 5x5 window
//   DP_ID_W  : width of the window index handed to the datapath
package gaussian_pkg;

    localparam int PIX_W   = 16;
    localparam int WIN_PIX = 25;
    localparam int DP_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        FEED = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/gaussian_seq.sv
// Gaussian window sequencer: streams the 25 raster-ordered pixels of each
// 5x5 window into an external gaussian datapath, waits DP_LAT cycles for
// the datapath result and hands it downstream over a valid/ready port.
// A frame is NUM_WIN windows started by a one-cycle start pulse.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a frame (ignored while busy)
//   in_valid/in_ready    upstream pixel handshake, in_pixel carries the pixel
//   dp_rst/dp_en         datapath clear / accumulate qualifier
//   dp_pixel/dp_id       pixel and its index within the window
//   dp_result            datapath output
//   out_valid/out_ready  result handshake, out_pixel carries the result
//   busy, frame_done     frame active; one-cycle end-of-frame pulse
//   perf_stall_cnt       stall counter
//
// Build option: define GAUSS_SEQ_PERF_EN to implement perf_stall_cnt,
// otherwise it is tied to zero.
module gaussian_seq #(
    parameter int PIX_W   = gaussian_pkg::PIX_W,
    parameter int WIN_PIX = gaussian_pkg::WIN_PIX,
    parameter int DP_LAT  = 1,
    parameter int NUM_WIN = 262144
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PIX_W-1:0]                 in_pixel,
    output logic                             dp_rst,
    output logic                             dp_en,
    output logic [PIX_W-1:0]                 dp_pixel,
    output logic [gaussian_pkg::DP_ID_W-1:0] dp_id,
    input  logic [PIX_W-1:0]                 dp_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PIX_W-1:0]                 out_pixel,
    output logic                             busy,
    output logic                             frame_done,
    output logic [31:0]                      perf_stall_cnt
);
    import gaussian_pkg::*;

    localparam int                 WC_W     = $clog2(NUM_WIN + 1);
    localparam logic [WC_W-1:0]    LAST_WIN = WC_W'(NUM_WIN);
    localparam logic [DP_ID_W-1:0] LAST_PIX = DP_ID_W'(WIN_PIX - 1);
    localparam logic [3:0]         LAT_C    = 4'(DP_LAT);

    state_t               state_r;
    state_t               state_s;
    logic [DP_ID_W-1:0]   pix_cnt_r;
    logic [DP_ID_W-1:0]   pix_cnt_s;
    logic [WC_W-1:0]      win_cnt_r;
    logic [WC_W-1:0]      win_cnt_s;
    logic [3:0]           lat_cnt_r;
    logic [3:0]           lat_cnt_s;
    logic                 xfer_s;
    logic                 capture_s;
    logic                 frame_end_s;

    // Next-state, counter updates and one-cycle strobes of the sequencer.
    always_comb begin
        state_s     = state_r;
        pix_cnt_s   = pix_cnt_r;
        win_cnt_s   = win_cnt_r;
        lat_cnt_s   = lat_cnt_r;
        xfer_s      = 1'b0;
        capture_s   = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = CLR;
                    win_cnt_s = {WC_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s   = FEED;
                pix_cnt_s = {DP_ID_W{1'b0}};
            end
            FEED: begin
                if (in_valid && in_ready) begin
                    xfer_s = 1'b1;
                    if (pix_cnt_r == LAST_PIX) begin
                        pix_cnt_s = {DP_ID_W{1'b0}};
                        lat_cnt_s = 4'd0;
                        state_s   = WAIT;
                    end else begin
                        pix_cnt_s = pix_cnt_r + DP_ID_W'(1);
                    end
                end else begin
                    state_s = FEED;
                end
            end
            WAIT: begin
                // lat_cnt_r counts cycles since the last dp_en cycle; the
                // result is valid once it reaches DP_LAT.
                if (lat_cnt_r != LAT_C) begin
                    lat_cnt_s = lat_cnt_r + 4'd1;
                end else if (!out_valid || out_ready) begin
                    capture_s = 1'b1;
                    win_cnt_s = win_cnt_r + WC_W'(1);
                    if (win_cnt_s == LAST_WIN) begin
                        // Frame complete: return to IDLE without a CLR pass.
                        state_s     = IDLE;
                        frame_end_s = 1'b1;
                    end else begin
                        state_s = CLR;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pix_cnt_r  <= {DP_ID_W{1'b0}};
            win_cnt_r  <= {WC_W{1'b0}};
            lat_cnt_r  <= 4'd0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            dp_rst     <= 1'b1;
            dp_en      <= 1'b0;
            dp_pixel   <= {PIX_W{1'b0}};
            dp_id      <= {DP_ID_W{1'b0}};
            out_valid  <= 1'b0;
            out_pixel  <= {PIX_W{1'b0}};
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            pix_cnt_r  <= pix_cnt_s;
            win_cnt_r  <= win_cnt_s;
            lat_cnt_r  <= lat_cnt_s;
            in_ready   <= (state_s == FEED);
            busy       <= (state_s != IDLE);
            dp_rst     <= (state_s == CLR);
            dp_en      <= xfer_s;
            frame_done <= frame_end_s;
            if (xfer_s) begin
                dp_pixel <= in_pixel;
                dp_id    <= pix_cnt_r;
            end
            // A capture wins over a consume so a same-cycle handoff keeps
            // out_valid high with the new value.
            if (capture_s) begin
                out_valid <= 1'b1;
                out_pixel <= dp_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef GAUSS_SEQ_PERF_EN
    logic        stall_s;
    logic [31:0] perf_cnt_r;

    assign stall_s = ((state_r == FEED) && !in_valid) ||
                     ((state_r == WAIT) && (lat_cnt_r == LAT_C) && out_valid && !out_ready);

    // Saturating stall counter, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_r <= 32'd0;
        end else if ((state_r == IDLE) && start) begin
            perf_cnt_r <= 32'd0;
        end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_cnt_r;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_gaussian_seq.sv
// Self-checking bench for gaussian_seq (NUM_WIN=2, DP_LAT=1). The datapath
// is modelled as an accumulator whose output is sum>>4. Pixels and window
// results are pushed to scoreboard queues as stimulus is driven and popped
// when dp_en / the output handshake shows them.
module tb_gaussian_seq;

    localparam int PIX_W   = 16;
    localparam int WIN_PIX = 25;
    localparam int DP_LAT  = 1;
    localparam int NUM_WIN = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [PIX_W-1:0] in_pixel  = '0;
    logic             in_ready;
    logic             dp_rst;
    logic             dp_en;
    logic [PIX_W-1:0] dp_pixel;
    logic [4:0]       dp_id;
    logic [PIX_W-1:0] dp_result;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             busy;
    logic             frame_done;
    logic [31:0]      perf_stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]      acc;
    logic [PIX_W-1:0] pix_q[$];
    logic [PIX_W-1:0] res_q[$];
    int               rise_q[$];
    int               exp_id     = 0;
    int               win_sum    = 0;
    int               win_pix    = 0;
    int               xfer_cyc   = 0;
    int               rst_pulses = 0;
    int               fd_pulses  = 0;
    int               fd_cyc     = -1;
    int               results    = 0;
    logic             prev_dp_rst = 1'b0;
    logic             prev_ov     = 1'b0;
    logic             prev_hold   = 1'b0;
    logic [PIX_W-1:0] prev_out    = '0;
    logic [PIX_W-1:0] mon_v;

    gaussian_seq #(
        .PIX_W  (PIX_W),
        .WIN_PIX(WIN_PIX),
        .DP_LAT (DP_LAT),
        .NUM_WIN(NUM_WIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .dp_rst        (dp_rst),
        .dp_en         (dp_en),
        .dp_pixel      (dp_pixel),
        .dp_id         (dp_id),
        .dp_result     (dp_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pixel     (out_pixel),
        .busy          (busy),
        .frame_done    (frame_done),
        .perf_stall_cnt(perf_stall_cnt)
    );

    // Clock.
    always #5 clk = ~clk;

    // Cycle counter (value k during the cycle after the k-th edge).
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: clear on dp_rst, accumulate on dp_en, result = sum>>4.
    always @(posedge clk) begin
        if (dp_rst) acc <= 32'd0;
        else if (dp_en) acc <= acc + 32'(dp_pixel);
    end
    assign dp_result = PIX_W'(acc >> 4);

    // Monitor on the falling edge: pixel stream, result scoreboard, pulses.
    always @(negedge clk) begin
        if (dp_rst && !prev_dp_rst) rst_pulses++;
        prev_dp_rst = dp_rst;
        if (frame_done) begin
            fd_pulses++;
            fd_cyc = cyc;
        end
        if (out_valid && !prev_ov) rise_q.push_back(cyc);
        if (prev_hold && rst_n) begin
            checks++;
            if (out_valid !== 1'b1 || out_pixel !== prev_out) begin
                errors++;
                $display("FAIL out_hold: out_valid=%b out_pixel=%0d required 1/%0d", out_valid, out_pixel, prev_out);
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_out  = out_pixel;
        if (out_valid && out_ready) begin
            checks++;
            results++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL out_result: unexpected result %0d, none pending", out_pixel);
            end else begin
                mon_v = res_q.pop_front();
                if (out_pixel !== mon_v) begin
                    errors++;
                    $display("FAIL out_result: out_pixel=%0d required %0d", out_pixel, mon_v);
                end
            end
        end
        if (dp_en) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL dp_stream: dp_en without a transfer, dp_id=%0d", dp_id);
            end else begin
                mon_v = pix_q.pop_front();
                if (dp_pixel !== mon_v || dp_id !== 5'(exp_id)) begin
                    errors++;
                    $display("FAIL dp_stream: dp_pixel=%0d dp_id=%0d required %0d/%0d", dp_pixel, dp_id, mon_v, exp_id);
                end
            end
            exp_id = (exp_id + 1) % WIN_PIX;
        end
        prev_ov = out_valid;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_pixel(input logic [PIX_W-1:0] p);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_pixel = p;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL send_pixel: in_ready=%b required 1 within 100 cycles", in_ready);
        end else begin
            pix_q.push_back(p);
            xfer_cyc = cyc;
            win_sum += int'(p);
            win_pix++;
            if (win_pix == WIN_PIX) begin
                res_q.push_back(PIX_W'(win_sum >> 4));
                win_sum = 0;
                win_pix = 0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_pixel(PIX_W'($urandom_range(0, 4095)));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy !== 1'b0 || out_valid !== 1'b0) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL wait_idle: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string name);
        logic [74:0] obs;
        logic [74:0] exp_v;
        obs   = {in_ready, dp_en, dp_pixel, dp_id, out_valid, out_pixel, busy, frame_done, perf_stall_cnt, dp_rst};
        exp_v = {1'b0, 1'b0, 16'd0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 32'd0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: outputs=%h required %h", name, obs, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dp_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: dp_rst=%b busy=%b required 0/0", dp_rst, busy);
        end
    endtask

    task automatic test_frame();
        int x1;
        int x2;
        int fd0;
        int r0;
        fd0 = fd_pulses;
        r0  = results;
        rise_q.delete();
        pulse_start();
        send_n(WIN_PIX);
        x1 = xfer_cyc;
        send_n(WIN_PIX);
        x2 = xfer_cyc;
        wait_idle();
        checks++;
        if (rise_q.size() != 2) begin
            errors++;
            $display("FAIL frame_results: out_valid rises=%0d required 2", rise_q.size());
        end else begin
            checks++;
            if (rise_q[0] != x1 + DP_LAT + 2 || rise_q[1] != x2 + DP_LAT + 2) begin
                errors++;
                $display("FAIL frame_latency: rises at %0d,%0d required %0d,%0d", rise_q[0], rise_q[1], x1 + DP_LAT + 2, x2 + DP_LAT + 2);
            end
            checks++;
            if (fd_cyc != rise_q[1]) begin
                errors++;
                $display("FAIL frame_done_time: cycle %0d required %0d", fd_cyc, rise_q[1]);
            end
        end
        checks++;
        if (fd_pulses - fd0 != 1 || results - r0 != 2) begin
            errors++;
            $display("FAIL frame_counts: frame_done cycles=%0d results=%0d required 1/2", fd_pulses - fd0, results - r0);
        end
        checks++;
        if (rst_pulses != 3) begin
            errors++;
            $display("FAIL dp_rst_pulses: %0d required 3", rst_pulses);
        end
    endtask

    task automatic test_in_stall();
        int r0;
        r0 = results;
        pulse_start();
        send_n(10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dp_en !== 1'b0 || dp_id !== 5'd9) begin
                errors++;
                $display("FAIL stall_gap: dp_en=%b dp_id=%0d required 0/9", dp_en, dp_id);
            end
        end
        send_n(WIN_PIX - 10);
        send_n(WIN_PIX);
        wait_idle();
        checks++;
        if (results - r0 != 2) begin
            errors++;
            $display("FAIL stall_results: %0d required 2", results - r0);
        end
        checks++;
`ifdef GAUSS_SEQ_PERF_EN
        if (perf_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_stall_cnt: %0d required 3", perf_stall_cnt);
        end
`else
        if (perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_stall_cnt: %0d required 0", perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        int r0;
        int fd0;
        logic [PIX_W-1:0] w1;
        r0  = results;
        fd0 = fd_pulses;
        out_ready = 1'b0;
        pulse_start();
        send_n(2 * WIN_PIX);
        w1 = res_q[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || frame_done !== 1'b0 ||
                out_valid !== 1'b1 || out_pixel !== w1) begin
                errors++;
                $display("FAIL bp_hold: busy=%b in_ready=%b frame_done=%b out_valid=%b out_pixel=%0d required 1/0/0/1/%0d",
                         busy, in_ready, frame_done, out_valid, out_pixel, w1);
            end
        end
        out_ready = 1'b1;
        wait_idle();
        checks++;
        if (results - r0 != 2 || fd_pulses - fd0 != 1) begin
            errors++;
            $display("FAIL bp_results: results=%0d frame_done cycles=%0d required 2/1", results - r0, fd_pulses - fd0);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        pulse_start();
        send_n(12);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        pix_q.delete();
        res_q.delete();
        win_sum = 0;
        win_pix = 0;
        exp_id  = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dp_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: dp_rst=%b required 0", dp_rst);
        end
        r0 = results;
        pulse_start();
        send_n(2 * WIN_PIX);
        wait_idle();
        checks++;
        if (results - r0 != 2) begin
            errors++;
            $display("FAIL reset_mid_results: %0d required 2", results - r0);
        end
    endtask

    task automatic test_start_ignored();
        int rp0;
        int fd0;
        int r0;
        rp0 = rst_pulses;
        fd0 = fd_pulses;
        r0  = results;
        pulse_start();
        send_n(5);
        start = 1'b1;
        send_pixel(PIX_W'($urandom_range(0, 4095)));
        start = 1'b0;
        send_n(WIN_PIX - 6);
        send_n(WIN_PIX);
        wait_idle();
        checks++;
        if (rst_pulses - rp0 != 2 || fd_pulses - fd0 != 1 || results - r0 != 2) begin
            errors++;
            $display("FAIL start_ignored: dp_rst pulses=%0d frame_done cycles=%0d results=%0d required 2/1/2",
                     rst_pulses - rp0, fd_pulses - fd0, results - r0);
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_frame();
        test_in_stall();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        checks++;
        if (pix_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pixels left=%0d results left=%0d required 0/0", pix_q.size(), res_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
